// File: rtl/spi_ram_burst_if.sv
// Frame-in / read-data-out handshake bundle for spi_ram_burst.
// The master side drives frames and the read-data ready; the slave is the RAM back end.
interface spi_ram_burst_if #(
  parameter int unsigned MEM_WIDTH = 8
);
  logic [MEM_WIDTH+1:0] din;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 err;

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid, err
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid, err
  );
endinterface

// File: rtl/spi_ram_burst.sv
// SPI RAM back end: executes decoded address/data frames against an internal memory,
// with optional pointer auto-increment, ready/valid handshakes and an illegal-command pulse.
module spi_ram_burst #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned MEM_WIDTH = 8,
   parameter int unsigned BURST_EN  = 1
) (
   input logic            clk,
   input logic            rst_n,
   spi_ram_burst_if.slave bus
);

   localparam logic [1:0] CmdWrAddr = 2'b00;
   localparam logic [1:0] CmdWrData = 2'b01;
   localparam logic [1:0] CmdRdAddr = 2'b10;
   localparam logic [1:0] CmdRdData = 2'b11;
   localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StTxHold} state_e;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic                 rd_armed_q, rd_armed_d;
   logic [MEM_WIDTH-1:0] dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 err_q, err_d;
   logic                 mem_we;

   logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

   logic [1:0]           cmd;
   logic [MEM_WIDTH-1:0] payload;
   logic [ADDR_SIZE-1:0] addr;
   logic                 addr_ok;
   logic                 accept;

   // Wrap by compare so non-power-of-two depths never step past the last word.
   function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] p);
      return (p == LastAddr) ? '0 : p + ADDR_SIZE'(1);
   endfunction

   assign cmd          = bus.din[MEM_WIDTH+1:MEM_WIDTH];
   assign payload      = bus.din[MEM_WIDTH-1:0];
   assign addr         = payload[ADDR_SIZE-1:0];
   assign addr_ok      = 32'(addr) < MEM_DEPTH;
   assign bus.rx_ready = rst_n && (state_q == StIdle);
   assign accept       = bus.rx_valid && bus.rx_ready;
   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.err      = err_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_armed_d = rd_armed_q;
      dout_d     = dout_q;
      tx_valid_d = tx_valid_q;
      err_d      = 1'b0;
      mem_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               unique case (cmd)
                  CmdWrAddr: begin
                     if (addr_ok) wr_ptr_d = addr;
                     else         err_d    = 1'b1;
                  end
                  CmdWrData: begin
                     mem_we = 1'b1;
                     if (BURST_EN != 0) wr_ptr_d = bump(wr_ptr_q);
                  end
                  CmdRdAddr: begin
                     if (addr_ok) begin
                        rd_ptr_d   = addr;
                        rd_armed_d = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  CmdRdData: begin
                     if (rd_armed_q) begin
                        dout_d     = mem[rd_ptr_q];
                        tx_valid_d = 1'b1;
                        state_d    = StTxHold;
                        if (BURST_EN != 0) rd_ptr_d   = bump(rd_ptr_q);
                        else               rd_armed_d = 1'b0;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StTxHold: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_armed_q <= 1'b0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_armed_q <= rd_armed_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         err_q      <= err_d;
      end
   end

   // Contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= payload;
   end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised next-generation SPI RAM back end. Consumes decoded SPI frames (2-bit control + MEM_WIDTH payload) from the SPI slave front end and executes write-address, write-data, read-address and read-data commands against an internal memory. Adds four things over the fixed 256x8 RAM:
- generic width and depth
- optional burst auto-increment of the address pointers
- a ready/valid handshake on both sides
- an error flag

Parameters:
MEM_DEPTH, 256, number of words; legal range 2..2**ADDR_SIZE
ADDR_SIZE, 8, address bits taken from payload[ADDR_SIZE-1:0]; must be <= MEM_WIDTH
MEM_WIDTH, 8, data word width
BURST_EN, 1, 1 = pointers auto-increment after each data access; 0 = pointers fixed

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  MEM_WIDTH+2  frame: [MEM_WIDTH+1:MEM_WIDTH] control (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA), [MEM_WIDTH-1:0] payload
rx_valid  input  1  din valid
rx_ready  output  1  block can accept a frame; frame accepted on rx_valid && rx_ready at a clock edge
dout  output  MEM_WIDTH  read data
tx_valid  output  1  dout valid
tx_ready  input  1  consumer accepts dout; transfer on tx_valid && tx_ready
err  output  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rx_ready=0 while rst_n low, tx_valid=0, dout=0, err=0, wr_ptr=0, rd_ptr=0, rd_armed=0. Memory contents are NOT cleared. Reset during TX_HOLD drops the pending read; no transfer occurs.
- FSM states:
  - IDLE: rx_ready=1.
  - TX_HOLD: rx_ready=0, tx_valid=1.
- IDLE, accepted WR_ADDR:
  - addr < MEM_DEPTH: wr_ptr <= addr.
  - else: err pulses next cycle, wr_ptr unchanged.
  - Stay IDLE.
- IDLE, accepted WR_DATA: mem[wr_ptr] <= payload. If BURST_EN, wr_ptr <= (wr_ptr==MEM_DEPTH-1) ? 0 : wr_ptr+1. Stay IDLE.
- IDLE, accepted RD_ADDR:
  - addr < MEM_DEPTH: rd_ptr <= addr, rd_armed <= 1.
  - else: err pulses, rd_ptr and rd_armed unchanged.
  - Stay IDLE.
- IDLE, accepted RD_DATA, payload ignored:
  - rd_armed=1: at that edge dout <= mem[rd_ptr], tx_valid <= 1, go to TX_HOLD. Latency: data visible the cycle after acceptance.
    - BURST_EN=1: rd_ptr increments with wrap at MEM_DEPTH-1 -> 0; rd_armed stays 1.
    - BURST_EN=0: rd_armed <= 0.
  - rd_armed=0: err pulses, no read, stay IDLE.
- TX_HOLD: dout and tx_valid held stable until tx_valid && tx_ready. On that edge tx_valid <= 0 and the FSM returns to IDLE, so rx_ready=1 the next cycle. dout keeps its last value afterwards.
- rx_valid while rx_ready=0: frame not consumed; sender must hold it. No state change.
- Read-after-write to the same address in consecutive accepted frames returns the newly written value. Memory is written at the WR_DATA edge, before the later RD_DATA read.
- err is a single-cycle registered pulse, asserted the cycle after the offending acceptance. At most one err per accepted frame.
- Pointers are ADDR_SIZE bits. Wrap uses compare-to-MEM_DEPTH-1, not natural overflow, so non-power-of-2 depths are legal.

Test Plan:
1. Reset, WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA with tx_ready=1 -> dout=0xA5, tx_valid high exactly 1 cycle, err never asserted.
2. BURST_EN=1: WR_ADDR 0xFE, WR_DATA 0x11/0x22/0x33; RD_ADDR 0xFE, three RD_DATA -> dout sequence 0x11, 0x22, 0x33 (addresses 0xFE, 0xFF, 0x00 wrap).
3. Backpressure: RD_DATA with tx_ready=0 for 5 cycles -> tx_valid=1 and dout stable for 5 cycles, rx_ready=0; next frame held on din not consumed until one cycle after tx_ready=1.
4. Errors: RD_DATA right after reset -> err pulse, tx_valid stays 0. MEM_DEPTH=200 build: WR_ADDR 0xC8 -> err pulse, wr_ptr unchanged, so a subsequent WR_DATA lands at the previous pointer.
5. BURST_EN=0: RD_ADDR 0x05, RD_DATA, RD_DATA -> first returns mem[5], second raises err with no tx_valid.
6. Assert rst_n low mid-TX_HOLD -> tx_valid, dout, err go 0 immediately (asynchronously). After release, a RD_ADDR 0x10 / RD_DATA sequence still returns the pre-reset memory value.
